// File: rtl/yu_gate_pkg.sv
// Shared types and helpers for the yu_gate AND cell and its activity counter.
package yu_gate_pkg;

  // Action the activity counter takes at a clock edge.
  typedef enum logic [1:0] {
    CntHold,
    CntInc,
    CntClr
  } cnt_op_e;

  // Clear wins over everything; increment only while all bits are high and headroom remains.
  function automatic cnt_op_e cnt_op(input logic clr, input logic all_high, input logic at_max);
    if (clr) begin
      return CntClr;
    end else if (all_high && !at_max) begin
      return CntInc;
    end else begin
      return CntHold;
    end
  endfunction

endpackage

// File: rtl/yu_gate_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module yu_gate_sat_counter
  import yu_gate_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  cnt_op_e          op;

  // Next-count selection; the all-ones check stops the counter from wrapping.
  always_comb begin
    op    = cnt_op(clr, en, &cnt_q);
    cnt_d = cnt_q;
    unique case (op)
      CntClr:  cnt_d = '0;
      CntInc:  cnt_d = cnt_q + CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Count register, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/yu_gate.sv
// Bitwise AND cell with a registered shadow copy, per-bit rising-edge pulses
// and a saturating count of edges at which every output bit is high.
module yu_gate
  import yu_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_q,
  output logic [WIDTH-1:0] c_rise,
  output logic [CNT_W-1:0] all_cnt
);

  logic [WIDTH-1:0] c_q_r;
  logic [WIDTH-1:0] c_rise_r;

  // Primary function: purely combinational, unaffected by clock, reset or clear.
  assign c = a & b;

  // Shadow copy and rise pulse; the pulse compares against the shadow before it updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q_r    <= '0;
      c_rise_r <= '0;
    end else begin
      c_q_r    <= c;
      c_rise_r <= c & ~c_q_r;
    end
  end

  assign c_q    = c_q_r;
  assign c_rise = c_rise_r;

  yu_gate_sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (&c),
    .cnt  (all_cnt)
  );

endmodule

// File: tb/tb_yu_gate.sv
// Scoreboard bench for yu_gate: a driver pushes expected registered results,
// a monitor pops and compares them just after each rising edge.
module tb_yu_gate;

  localparam int W    = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [W-1:0]  c_q;
    logic [W-1:0]  c_rise;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk;
  logic          clk_en;
  logic          rst_n;
  logic [W-1:0]  a, b;
  logic          clr;
  logic [W-1:0]  c, c_q, c_rise;
  logic [CW-1:0] all_cnt;

  logic          a1, b1, clr1;
  logic          c1, c_q1, c_rise1;
  logic [15:0]   all_cnt1;

  int checks   = 0;
  int failures = 0;

  exp_t sb[$];

  // Reference state: last value of a&b sampled at an edge and the count as a plain integer.
  logic [W-1:0] m_prev;
  int           m_cnt;

  yu_gate #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .clr    (clr),
    .c      (c),
    .c_q    (c_q),
    .c_rise (c_rise),
    .all_cnt(all_cnt)
  );

  yu_gate #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a1),
    .b      (b1),
    .clr    (clr1),
    .c      (c1),
    .c_q    (c_q1),
    .c_rise (c_rise1),
    .all_cnt(all_cnt1)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: apply inputs, check c, predict the edge, advance to next negedge.
  task automatic step(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    exp_t e;
    logic [W-1:0] cc;
    a   = av;
    b   = bv;
    clr = cv;
    #1;
    cc = av & bv;
    check("c_comb", 32'(c), 32'(cc));
    e.c_q    = cc;
    e.c_rise = cc & ~m_prev;
    if (cv) m_cnt = 0;
    else if (cc == {W{1'b1}}) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
    e.cnt  = CW'(m_cnt);
    m_prev = cc;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Assert reset between edges and verify the registered outputs drop without a clock edge.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_c_q", 32'(c_q), 32'd0);
    check("rst_c_rise", 32'(c_rise), 32'd0);
    check("rst_all_cnt", 32'(all_cnt), 32'd0);
    check("rst_c_follows", 32'(c), 32'(a & b));
    sb.delete();
    m_prev = '0;
    m_cnt  = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare every pending prediction just after the edge it belongs to.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("c_q", 32'(c_q), 32'(e.c_q));
        check("c_rise", 32'(c_rise), 32'(e.c_rise));
        check("all_cnt", 32'(all_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    clk_en = 1'b0;
    rst_n  = 1'b0;
    a = '0; b = '0; clr = 1'b0;
    a1 = 1'b0; b1 = 1'b0; clr1 = 1'b0;
    m_prev = '0;
    m_cnt  = 0;

    // Truth table with no clock and reset held.
    #1  check("tt_00", 32'(c1), 32'd0);
    #99 a1 = 1'b1;
    #1  check("tt_10", 32'(c1), 32'd0);
    #99 b1 = 1'b1;
    #1  check("tt_11", 32'(c1), 32'd1);
    check("rst_init_c_q", 32'(c_q), 32'd0);
    check("rst_init_cnt", 32'(all_cnt), 32'd0);
    check("rst_init_cnt1", 32'(all_cnt1), 32'd0);

    // Release reset with a&b all ones: first edge must pulse c_rise and count 1.
    a = '1; b = '1;
    clk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step('1, '1, 1'b0);
    b1 = 1'b0;
    for (int i = 0; i < 3; i++) step('1, '1, 1'b0);
    check("cnt1_hold10", 32'(all_cnt1), 32'd10);
    check("c_q1_low", 32'(c_q1), 32'd0);
    check("c_rise1_low", 32'(c_rise1), 32'd0);

    // Async reset mid-count with a=b=all ones.
    pulse_reset();

    // Edge pulse 0000 -> 0101 -> hold.
    step('0, '0, 1'b0);
    step(4'b0101, 4'b0101, 1'b0);
    step(4'b0101, 4'b0101, 1'b0);
    step(4'b0101, 4'b1111, 1'b0);

    // Counting then saturation, then clear at saturation, then resume.
    for (int i = 0; i < 12; i++) step('1, '1, 1'b0);
    step('1, '1, 1'b1);
    step('1, '1, 1'b0);
    step('1, 4'b1110, 1'b0);
    step('1, '1, 1'b1);

    // Randomized traffic biased toward all-ones so the counter moves.
    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? W'($urandom) : '1;
      rb = ($urandom_range(0, 2) == 0) ? W'($urandom) : '1;
      if ($urandom_range(0, 39) == 0) pulse_reset();
      else step(ra, rb, $urandom_range(0, 9) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
